bcd_scan_counter: RTL and testbench
===================================

Name: bcd_scan_counter

Overview:
- Multi-digit BCD up/down counter with an integrated digit-scan multiplexer.
- Sits directly upstream of the 7-segment decoder. Presents one BCD digit (0-9) at a time on a 4-bit bus, with a one-hot digit-select for a time-multiplexed display.
- Counting is rate-controlled by an internal prescaler. The scan runs independently of the count.

Parameters:
- DIGITS, 4: number of BCD digits (1-8). Digit 0 is the least significant.
- PRESCALE, 1: enabled clock cycles per count step (>=1).
- SCAN_DIV, 4: clock cycles each digit stays selected (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- en  in  1  count enable; gates the prescaler.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous load strobe.
- load_val  in  4*DIGITS  packed BCD load value; digit i is at bits [4i+3:4i].
- count  out  4*DIGITS  packed BCD count value.
- carry  out  1  one-cycle pulse on wrap.
- digit_out  out  4  BCD value of the selected digit; feeds the decoder x3..x0.
- digit_sel  out  DIGITS  one-hot select for the digit currently on digit_out.

Behaviour:
- Reset and clocking: one clock. Synchronous active-low reset: all state is updated only on the rising edge of clk, and rst_n low at an edge resets the block.
- Reset values: count=0, carry=0, digit_out=0, digit_sel=1 (digit 0), prescaler=0, scan counter=0.
- Priority per edge: reset > load > count step.
- Load:
  - count <= load_val, with each nibble >9 clamped to 9.
  - Prescaler cleared; carry=0 that cycle.
  - Scan state is not affected.
- Prescaler:
  - When en=1 it counts 0..PRESCALE-1. A step occurs on the cycle the prescaler is at PRESCALE-1, and the prescaler then returns to 0.
  - PRESCALE=1 gives a step on every en cycle.
  - en=0 holds both the prescaler and count.
- Step, up=1: ripple BCD increment. A digit at 9 becomes 0 and carries into the next digit. All digits at 9 wrap to all 0 and carry=1 for exactly that cycle.
- Step, up=0: ripple BCD decrement. A digit at 0 becomes 9 and borrows from the next digit. All digits at 0 wrap to all 9 and carry=1 for that cycle.
- carry is registered and aligned with the wrapped count value. Otherwise carry=0.
- Direction change takes effect on the next step; no glitch, no extra step.
- Scan:
  - Free-running counter 0..SCAN_DIV-1. At the terminal value, digit_sel rotates left (MSB wraps to bit 0).
  - digit_out is registered and always equals the nibble of count selected by digit_sel, with a one-cycle lag: digit_out reflects the count as of the previous edge.
  - DIGITS=1: digit_sel stays 1.
- Invariants: every nibble of count is in 0..9 at all times. digit_sel is always exactly one-hot.
- Reset mid-operation: all state returns to reset values on that edge; no carry pulse is emitted.

Optional Feature:
- Macro: BCD_SATURATE_EN.
- Defined:
  - Up-count holds at all 9s; down-count holds at all 0s.
  - carry pulses once on the step that would have wrapped; count does not change.
  - Further steps at the limit produce no further carry.
- Undefined: wrap-around behaviour as described above.

Test Plan:
All scenarios use DIGITS=2, PRESCALE=1, SCAN_DIV=2 unless stated.
- Reset: hold rst_n=0 for 3 cycles, then release -> count=8'h00, digit_sel=2'b01, digit_out=0, carry=0.
- Up wrap: load 8'h98, en=1, up=1 -> count 99 then 00; carry=1 only on the 00 cycle.
- Down wrap: load 8'h01, up=0 -> count 00 then 99; carry=1 with 99. With BCD_SATURATE_EN, count stays 00, carry pulses once, and later steps give carry=0.
- Load clamp and priority: load_val=8'hA7 with en=1 in the same cycle -> count=8'h97, no step that cycle.
- Prescaler (PRESCALE=3, en=1, up=1, from 00): count steps on cycles 3, 6 and 9 only. Drop en=0 for 5 cycles -> count and prescaler hold.
- Scan: count=8'h42 static -> digit_sel sequence 01,01,10,10,01,... and digit_out 2,2,4,4,2,... (one cycle after digit_sel). Assert rst_n=0 mid-scan -> digit_sel=01 on the next edge.

Source files
------------

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with prescaled stepping and a free-running digit scan mux.
// Define BCD_SATURATE_EN to hold at all-9s/all-0s instead of wrapping.

module bcd_scan_digit (
    input  logic       ci,
    input  logic       up,
    input  logic [3:0] d,
    input  logic [3:0] ld_raw,
    output logic [3:0] nd,
    output logic       co,
    output logic [3:0] ld
);
    always_comb begin
        nd = d;
        co = 1'b0;
        if (ci) begin
            if (up) begin
                if (d >= 4'd9) begin
                    nd = 4'd0;
                    co = 1'b1;
                end else begin
                    nd = d + 4'd1;
                end
            end else begin
                if (d == 4'd0) begin
                    nd = 4'd9;
                    co = 1'b1;
                end else begin
                    nd = d - 4'd1;
                end
            end
        end
    end

    assign ld = (ld_raw > 4'd9) ? 4'd9 : ld_raw;
endmodule

module bcd_scan_counter #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1,
    parameter int SCAN_DIV = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                carry,
    output logic [3:0]          digit_out,
    output logic [DIGITS-1:0]   digit_sel
);
    localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(SCAN_DIV - 1);

    logic [DIGITS-1:0][3:0] cnt, cnt_nxt, ld_clamp;
    logic [DIGITS:0]        chain;
    logic [PSW-1:0]         ps;
    logic [SCW-1:0]         sc;
    logic [DIGITS-1:0]      sel, sel_rot;
    logic [3:0]             sel_nib;
    logic                   step, wrap;

    assign step     = en && (ps == PS_LAST);
    assign chain[0] = step;
    // Top-digit carry/borrow out means every digit sat at its limit.
    assign wrap     = chain[DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_scan_digit u_dig (
            .ci     (chain[g]),
            .up     (up),
            .d      (cnt[g]),
            .ld_raw (load_val[4*g +: 4]),
            .nd     (cnt_nxt[g]),
            .co     (chain[g+1]),
            .ld     (ld_clamp[g])
        );
    end

`ifdef BCD_SATURATE_EN
    // Set once the limit pulse has been emitted; cleared whenever count moves or is loaded.
    logic sat_hit;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            ps    <= '0;
            carry <= 1'b0;
`ifdef BCD_SATURATE_EN
            sat_hit <= 1'b0;
`endif
        end else if (load) begin
            cnt   <= ld_clamp;
            ps    <= '0;
            carry <= 1'b0;
`ifdef BCD_SATURATE_EN
            sat_hit <= 1'b0;
`endif
        end else begin
            carry <= 1'b0;
            if (en) begin
                ps <= step ? '0 : ps + 1'b1;
`ifdef BCD_SATURATE_EN
                if (wrap) begin
                    carry   <= !sat_hit;
                    sat_hit <= 1'b1;
                end else begin
                    cnt <= cnt_nxt;
                    if (step)
                        sat_hit <= 1'b0;
                end
`else
                cnt   <= cnt_nxt;
                carry <= wrap;
`endif
            end
        end
    end

    if (DIGITS == 1) begin : g_rot1
        assign sel_rot = sel;
    end else begin : g_rotn
        assign sel_rot = {sel[DIGITS-2:0], sel[DIGITS-1]};
    end

    always_comb begin
        sel_nib = '0;
        for (int i = 0; i < DIGITS; i++)
            if (sel[i])
                sel_nib = sel_nib | cnt[i];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sc        <= '0;
            sel       <= DIGITS'(1);
            digit_out <= '0;
        end else begin
            digit_out <= sel_nib;
            if (sc == SC_LAST) begin
                sc  <= '0;
                sel <= sel_rot;
            end else begin
                sc <= sc + 1'b1;
            end
        end
    end

    assign count     = cnt;
    assign digit_sel = sel;
endmodule

// File: tb/tb_bcd_scan_counter.sv
// Randomized + directed bench for bcd_scan_counter; two instances (2-digit fast, 3-digit prescaled)
// checked every cycle against a decimal-arithmetic reference model.

module tb_bcd_scan_counter;
    logic        clk = 1'b0;
    logic        rst_n, en, up, load;
    logic [7:0]  load_val1, count1;
    logic [11:0] load_val2, count2;
    logic        carry1, carry2;
    logic [3:0]  dout1, dout2;
    logic [1:0]  sel1;
    logic [2:0]  sel2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bcd_scan_counter #(.DIGITS(2), .PRESCALE(1), .SCAN_DIV(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val1),
        .count(count1), .carry(carry1), .digit_out(dout1), .digit_sel(sel1));

    bcd_scan_counter #(.DIGITS(3), .PRESCALE(3), .SCAN_DIV(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val2),
        .count(count2), .carry(carry2), .digit_out(dout2), .digit_sel(sel2));

    typedef struct {
        int val; int ps; int sc; int sel; int dout; bit carry; bit sat;
    } mst_t;

    mst_t m1, m2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v, input int d);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference: count held as a plain decimal integer.
    function automatic mst_t mstep(input mst_t m, input int d, input int p, input int s,
                                   input bit r, input bit e, input bit u, input bit l,
                                   input logic [31:0] lv);
        mst_t n = m;
        int lim = 10 ** d;
        bit lim_hit;
        n.carry = 1'b0;
        if (!r) begin
            n.val = 0; n.ps = 0; n.sc = 0; n.sel = 0; n.dout = 0; n.sat = 1'b0;
            return n;
        end
        n.dout = (m.val / (10 ** m.sel)) % 10;
        if (m.sc == s - 1) begin
            n.sc = 0;
            n.sel = (m.sel + 1) % d;
        end else begin
            n.sc = m.sc + 1;
        end
        if (l) begin
            n.val = 0;
            for (int i = 0; i < d; i++) begin
                int nib = int'((lv >> (4 * i)) & 32'hF);
                if (nib > 9) nib = 9;
                n.val += nib * (10 ** i);
            end
            n.ps = 0;
            n.sat = 1'b0;
        end else if (e) begin
            if (m.ps == p - 1) begin
                n.ps = 0;
                lim_hit = u ? (m.val == lim - 1) : (m.val == 0);
`ifdef BCD_SATURATE_EN
                if (lim_hit) begin
                    n.carry = !m.sat;
                    n.sat = 1'b1;
                end else begin
                    n.val = u ? m.val + 1 : m.val - 1;
                    n.sat = 1'b0;
                end
`else
                n.val = u ? (m.val + 1) % lim : (m.val + lim - 1) % lim;
                n.carry = lim_hit;
`endif
            end else begin
                n.ps = m.ps + 1;
            end
        end
        return n;
    endfunction

    task automatic tick(input bit r, input bit e, input bit u, input bit l,
                        input logic [7:0] lv1, input logic [11:0] lv2);
        rst_n = r; en = e; up = u; load = l; load_val1 = lv1; load_val2 = lv2;
        @(posedge clk);
        m1 = mstep(m1, 2, 1, 2, r, e, u, l, 32'(lv1));
        m2 = mstep(m2, 3, 3, 3, r, e, u, l, 32'(lv2));
        @(negedge clk);
        chk("cnt1",  32'(count1), to_bcd(m1.val, 2));
        chk("cry1",  32'(carry1), 32'(m1.carry));
        chk("dout1", 32'(dout1),  32'(m1.dout));
        chk("sel1",  32'(sel1),   32'(1) << m1.sel);
        chk("cnt2",  32'(count2), to_bcd(m2.val, 3));
        chk("cry2",  32'(carry2), 32'(m2.carry));
        chk("dout2", 32'(dout2),  32'(m2.dout));
        chk("sel2",  32'(sel2),   32'(1) << m2.sel);
    endtask

    int esel[5] = '{2, 2, 1, 1, 2};
    int edo[5]  = '{2, 4, 4, 2, 2};

    initial begin
        bit r, e, u, l;
        logic [7:0] lv1;
        logic [11:0] lv2;
        m1 = '{default: 0};
        m2 = '{default: 0};

        // reset
        repeat (3) tick(0, 0, 1, 0, 8'h00, 12'h000);
        tick(1, 0, 1, 0, 8'h00, 12'h000);
        chk("rst_cnt", 32'(count1), 32'h00);
        chk("rst_sel", 32'(sel1), 32'h1);
        chk("rst_dout", 32'(dout1), 32'h0);
        chk("rst_cry", 32'(carry1), 32'h0);

        // up wrap
        tick(1, 1, 1, 1, 8'h98, 12'h998);
        chk("ld98", 32'(count1), 32'h98);
        tick(1, 1, 1, 0, 8'h00, 12'h000);
        chk("up99", 32'(count1), 32'h99);
        chk("up99_c", 32'(carry1), 32'h0);
        tick(1, 1, 1, 0, 8'h00, 12'h000);
`ifdef BCD_SATURATE_EN
        chk("upwrap", 32'(count1), 32'h99);
`else
        chk("upwrap", 32'(count1), 32'h00);
`endif
        chk("upwrap_c", 32'(carry1), 32'h1);
        tick(1, 1, 1, 0, 8'h00, 12'h000);
`ifdef BCD_SATURATE_EN
        chk("uppost", 32'(count1), 32'h99);
`else
        chk("uppost", 32'(count1), 32'h01);
`endif
        chk("uppost_c", 32'(carry1), 32'h0);

        // down wrap
        tick(1, 1, 0, 1, 8'h01, 12'h001);
        tick(1, 1, 0, 0, 8'h00, 12'h000);
        chk("dn00", 32'(count1), 32'h00);
        chk("dn00_c", 32'(carry1), 32'h0);
        tick(1, 1, 0, 0, 8'h00, 12'h000);
`ifdef BCD_SATURATE_EN
        chk("dnwrap", 32'(count1), 32'h00);
`else
        chk("dnwrap", 32'(count1), 32'h99);
`endif
        chk("dnwrap_c", 32'(carry1), 32'h1);
        tick(1, 1, 0, 0, 8'h00, 12'h000);
`ifdef BCD_SATURATE_EN
        chk("dnpost", 32'(count1), 32'h00);
`else
        chk("dnpost", 32'(count1), 32'h98);
`endif
        chk("dnpost_c", 32'(carry1), 32'h0);

        // load clamp wins over step
        tick(1, 1, 1, 1, 8'hA7, 12'hFA3);
        chk("clamp1", 32'(count1), 32'h97);
        chk("clamp_c", 32'(carry1), 32'h0);
        chk("clamp2", 32'(count2), 32'h993);
        tick(1, 0, 1, 0, 8'h00, 12'h000);
        chk("hold97", 32'(count1), 32'h97);

        // prescaler on the 3-digit instance
        tick(1, 1, 1, 1, 8'h00, 12'h000);
        for (int k = 1; k <= 9; k++) begin
            tick(1, 1, 1, 0, 8'h00, 12'h000);
            chk("ps_step", 32'(count2), 32'(k / 3));
        end
        repeat (5) begin
            tick(1, 0, 1, 0, 8'h00, 12'h000);
            chk("ps_hold", 32'(count2), 32'h003);
        end
        for (int k = 1; k <= 3; k++) begin
            tick(1, 1, 1, 0, 8'h00, 12'h000);
            chk("ps_resume", 32'(count2), (k == 3) ? 32'h004 : 32'h003);
        end

        // scan sequence with static 42
        tick(0, 0, 1, 0, 8'h00, 12'h000);
        tick(1, 0, 1, 1, 8'h42, 12'h042);
        chk("scan_sel0", 32'(sel1), 32'h1);
        chk("scan_do0", 32'(dout1), 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick(1, 0, 1, 0, 8'h00, 12'h000);
            chk("scan_sel", 32'(sel1), 32'(esel[k]));
            chk("scan_do", 32'(dout1), 32'(edo[k]));
        end
        tick(0, 0, 1, 0, 8'h00, 12'h000);
        chk("scan_rst_sel", 32'(sel1), 32'h1);
        chk("scan_rst_do", 32'(dout1), 32'h0);
        chk("scan_rst_cnt", 32'(count1), 32'h00);

        // random traffic, biased toward the limits
        repeat (400) begin
            r = ($urandom_range(0, 49) != 0);
            e = ($urandom_range(0, 3) != 0);
            u = 1'($urandom_range(0, 1));
            l = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 5))
                0: begin lv1 = 8'h99; lv2 = 12'h999; end
                1: begin lv1 = 8'h98; lv2 = 12'h998; end
                2: begin lv1 = 8'h00; lv2 = 12'h000; end
                3: begin lv1 = 8'h01; lv2 = 12'h001; end
                default: begin lv1 = 8'($urandom); lv2 = 12'($urandom); end
            endcase
            tick(r, e, u, l, lv1, lv2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
